rv32_lsu: RTL and testbench

- Core-side load/store unit between the pipelined RV32I core's MEM stage and a handshake-based, word-organised data memory with byte enables.
- Turns one RV32I load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) into one word-granular memory transaction.
- Performs byte-lane steering, sign/zero extension and misalignment/illegal-size detection.
- Drives a busy signal so the core stalls until the access completes.

---
 rtl/rv32_lsu.sv | 166 ++++++++++++++++
 tb/tb_rv32_lsu.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_lsu.sv
// rv32_lsu -- load/store unit between the RV32I MEM stage and a word-organised
// data memory with byte enables and a req/gnt + rvalid handshake.
//
// One core request (LB/LH/LW/LBU/LHU/SB/SH/SW) becomes one word-granular
// memory transaction. Misaligned or illegal-funct3 accesses complete with
// io_err and generate no memory traffic. io_busy stalls the core while the
// access is in flight.
//
// Ports:
//   clock, reset                asynchronous active-high reset
//   io_req_valid/we/funct3/addr/wdata   core request (sampled only in IDLE)
//   io_busy                     high in every state except IDLE
//   io_done, io_err             one-cycle completion pulse; err valid with done
//   io_rdata                    extended load result, held until next load
//   io_mem_req/we/addr/be/wdata memory request, held until io_mem_gnt
//   io_mem_gnt                  memory accepts the request this cycle
//   io_mem_rvalid/rdata         read response (loads only)
module rv32_lsu #(
  parameter int DMEM_AW    = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_req_valid,
  input  logic                  io_req_we,
  input  logic [2:0]            io_req_funct3,
  input  logic [31:0]           io_req_addr,
  input  logic [DATA_WIDTH-1:0] io_req_wdata,
  output logic                  io_busy,
  output logic                  io_done,
  output logic                  io_err,
  output logic [DATA_WIDTH-1:0] io_rdata,
  output logic                  io_mem_req,
  output logic                  io_mem_we,
  output logic [DMEM_AW-1:0]    io_mem_addr,
  output logic [3:0]            io_mem_be,
  output logic [DATA_WIDTH-1:0] io_mem_wdata,
  input  logic                  io_mem_gnt,
  input  logic                  io_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] io_mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [2:0]              funct3_reg;
  logic [1:0]              offset_reg;
  logic                    we_reg;
  logic                    err_reg;
  logic [DMEM_AW-1:0]      mem_addr_reg;
  logic [3:0]              be_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;

  logic                    legal;
  logic                    accept;
  logic [3:0]              be_calc;
  logic [DATA_WIDTH-1:0]   wdata_calc;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   load_ext;

  // Address bits above the memory word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^io_req_addr[31:DMEM_AW+2];

  // Legality: size must be a real RV32I load/store encoding and naturally
  // aligned; stores have no unsigned variants.
  always_comb begin
    legal = 1'b0;
    case (io_req_funct3)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~io_req_addr[0];
      3'b010:         legal = (io_req_addr[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
    if (io_req_we && io_req_funct3[2]) legal = 1'b0;
  end

  // Byte-lane steering for the outgoing request.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = io_req_wdata;
    case (io_req_funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << io_req_addr[1:0];
        wdata_calc = {4{io_req_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << io_req_addr[1:0];
        wdata_calc = {2{io_req_wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = io_req_wdata;
      end
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted  = io_mem_rdata >> {offset_reg, 3'b000};
    load_ext = shifted;
    case (funct3_reg)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  assign accept = (state_reg == IDLE) && io_req_valid;

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (io_req_valid) state_next = legal ? REQ : DONE;
      REQ:  if (io_mem_gnt)   state_next = we_reg ? DONE : RESP;
      RESP: if (io_mem_rvalid) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      funct3_reg   <= 3'b000;
      offset_reg   <= 2'b00;
      we_reg       <= 1'b0;
      err_reg      <= 1'b0;
      mem_addr_reg <= '0;
      be_reg       <= 4'b0000;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        funct3_reg   <= io_req_funct3;
        offset_reg   <= io_req_addr[1:0];
        we_reg       <= io_req_we;
        err_reg      <= ~legal;
        mem_addr_reg <= io_req_addr[DMEM_AW+1:2];
        be_reg       <= be_calc;
        wdata_reg    <= wdata_calc;
      end
      if (state_reg == RESP && io_mem_rvalid) begin
        rdata_reg <= load_ext;
      end
    end
  end

  // Request/status outputs decode straight from the state register so that
  // an asynchronous reset drops them in the same instant.
  assign io_busy      = (state_reg != IDLE);
  assign io_done      = (state_reg == DONE);
  assign io_err       = (state_reg == DONE) && err_reg;
  assign io_rdata     = rdata_reg;
  assign io_mem_req   = (state_reg == REQ);
  assign io_mem_we    = (state_reg == REQ) && we_reg;
  assign io_mem_addr  = mem_addr_reg;
  assign io_mem_be    = be_reg;
  assign io_mem_wdata = wdata_reg;

endmodule

// File: tb/tb_rv32_lsu.sv
// tb_rv32_lsu -- self-checking bench for rv32_lsu. A small reference model
// computes expected results when each request is driven; they are queued and
// popped when the DUT presents memory traffic or completes.
module tb_rv32_lsu;

  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          io_busy, io_done, io_err;
  logic [31:0]   io_rdata;
  logic          io_mem_req, io_mem_we;
  logic [AW-1:0] io_mem_addr;
  logic [3:0]    io_mem_be;
  logic [31:0]   io_mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = 32'h0;

  rv32_lsu #(.DMEM_AW(AW), .DATA_WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_req_valid  (req_valid),
    .io_req_we     (req_we),
    .io_req_funct3 (req_funct3),
    .io_req_addr   (req_addr),
    .io_req_wdata  (req_wdata),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_err        (io_err),
    .io_rdata      (io_rdata),
    .io_mem_req    (io_mem_req),
    .io_mem_we     (io_mem_we),
    .io_mem_addr   (io_mem_addr),
    .io_mem_be     (io_mem_be),
    .io_mem_wdata  (io_mem_wdata),
    .io_mem_gnt    (mem_gnt),
    .io_mem_rvalid (mem_rvalid),
    .io_mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } mem_exp_t;

  exp_t     exp_q[$];
  mem_exp_t mem_q[$];

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_rdata = 32'h0;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic legal_of(input logic we, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 1'b1;
      3'b100:  return !we;
      3'b001:  return a[0] == 1'b0;
      3'b101:  return !we && a[0] == 1'b0;
      3'b010:  return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a[1:0];
      2'b01:   return 4'b0011 << a[1:0];
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wd_of(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ext_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * a[1:0]);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  // Drive one request and act as the memory: grant after gdly extra cycles,
  // return read data rdly extra cycles after the earliest legal slot. If
  // inject equals the cycle count, a stray request is pulsed while busy.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] memword,
                        input int gdly, input int rdly, input int inject);
    logic     legal;
    logic     done_seen;
    exp_t     e;
    mem_exp_t m;
    mem_exp_t mm;
    int       k, reqc, respc;
    legal = legal_of(we, f3, addr);
    if (legal && !we) model_rdata = ext_of(f3, addr, memword);
    e.err   = !legal;
    e.rdata = model_rdata;
    e.lat   = !legal ? 1 : (we ? 2 + gdly : 3 + gdly + rdly);
    exp_q.push_back(e);
    if (legal) begin
      m.addr  = {22'h0, addr[AW+1:2]};
      m.be    = be_of(f3, addr);
      m.wdata = wd_of(f3, wdata);
      m.we    = we;
      mem_q.push_back(m);
    end
    mm = '{addr: 32'h0, be: 4'h0, wdata: 32'h0, we: 1'b0};
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clock);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    k = 1; reqc = 0; respc = 0; done_seen = 1'b0;
    while (!done_seen && k < 60) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (io_done) begin
        e = exp_q.pop_front();
        obs_err = io_err; obs_rdata = io_rdata;
        check_eq("done_err", {31'h0, io_err}, {31'h0, e.err});
        check_eq("done_rdata", io_rdata, e.rdata);
        check_eq("done_latency", k, e.lat);
        if (legal) check_eq("req_cycles", reqc, gdly + 1);
        $display("txn we=%0d f3=%0d addr=%h err=%0d rdata=%h lat=%0d",
                 we, f3, addr, io_err, io_rdata, k);
        done_seen = 1'b1;
      end else begin
        check_eq("busy", {31'h0, io_busy}, 32'h1);
        check_eq("err_without_done", {31'h0, io_err}, 32'h0);
        if (!legal) check_eq("no_mem_req", {31'h0, io_mem_req}, 32'h0);
        if (io_mem_req) begin
          if (reqc == 0) begin
            if (mem_q.size() > 0) mm = mem_q.pop_front();
            else check_eq("unexpected_mem_req", 32'h1, 32'h0);
            obs_addr = {22'h0, io_mem_addr}; obs_be = io_mem_be; obs_wdata = io_mem_wdata;
          end
          check_eq("mem_addr", {22'h0, io_mem_addr}, mm.addr);
          check_eq("mem_be", {28'h0, io_mem_be}, {28'h0, mm.be});
          check_eq("mem_wdata", io_mem_wdata, mm.wdata);
          check_eq("mem_we", {31'h0, io_mem_we}, {31'h0, mm.we});
          reqc++;
          if (reqc > gdly) mem_gnt = 1'b1;
        end else if (legal && !we && reqc > 0) begin
          respc++;
          if (respc > rdly) begin
            mem_rvalid = 1'b1; mem_rdata = memword;
          end
        end
      end
      if (inject == k) begin
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h44;
      end else begin
        req_valid = 1'b0;
      end
      if (!done_seen) begin
        @(negedge clock);
        k++;
      end
    end
    if (!done_seen) check_eq("done_timeout", 32'h1, 32'h0);
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clock);
    check_eq("idle_after_done", {31'h0, io_busy}, 32'h0);
    check_eq("single_done", {31'h0, io_done}, 32'h0);
  endtask

  initial begin
    #1;
    check_eq("rst_busy", {31'h0, io_busy}, 32'h0);
    check_eq("rst_done", {31'h0, io_done}, 32'h0);
    check_eq("rst_mem_req", {31'h0, io_mem_req}, 32'h0);
    check_eq("rst_rdata", io_rdata, 32'h0);
    check_eq("rst_be", {28'h0, io_mem_be}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // SW, immediate grant
    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 0);
    check_eq("tp_sw_addr", obs_addr, 32'h4);
    check_eq("tp_sw_be", {28'h0, obs_be}, 32'hF);
    check_eq("tp_sw_wdata", obs_wdata, 32'hDEADBEEF);

    // SB then LB / LBU on the top byte lane
    access(1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 0, 0, 0);
    check_eq("tp_sb_be", {28'h0, obs_be}, 32'h8);
    check_eq("tp_sb_wdata", obs_wdata, 32'hA5A5A5A5);
    access(1'b0, 3'b000, 32'h13, 32'h0, 32'hA5123456, 0, 0, 0);
    check_eq("tp_lb", obs_rdata, 32'hFFFFFFA5);
    access(1'b0, 3'b100, 32'h13, 32'h0, 32'hA5123456, 0, 0, 0);
    check_eq("tp_lbu", obs_rdata, 32'h000000A5);

    // LH / LHU upper half
    access(1'b0, 3'b001, 32'h2, 32'h0, 32'h80011234, 0, 0, 0);
    check_eq("tp_lh", obs_rdata, 32'hFFFF8001);
    access(1'b0, 3'b101, 32'h2, 32'h0, 32'h80011234, 0, 0, 0);
    check_eq("tp_lhu", obs_rdata, 32'h00008001);

    // Illegal accesses: done+err next cycle, no traffic, rdata held
    access(1'b0, 3'b010, 32'h6, 32'h0, 32'h11111111, 0, 0, 0);
    check_eq("tp_lw_mis_err", {31'h0, obs_err}, 32'h1);
    check_eq("tp_lw_mis_rdata", obs_rdata, 32'h00008001);
    access(1'b1, 3'b001, 32'h3, 32'h12345678, 32'h0, 0, 0, 0);
    check_eq("tp_sh_mis_err", {31'h0, obs_err}, 32'h1);
    access(1'b0, 3'b011, 32'h0, 32'h0, 32'h22222222, 0, 0, 0);
    check_eq("tp_f3_011_err", {31'h0, obs_err}, 32'h1);
    check_eq("tp_f3_011_rdata", obs_rdata, 32'h00008001);
    access(1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    check_eq("tp_sbu_err", {31'h0, obs_err}, 32'h1);

    // Stalled grant (3 cycles), rvalid 2 cycles after grant, stray request
    access(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 3, 1, 2);
    check_eq("tp_stall_rdata", obs_rdata, 32'hCAFEF00D);

    // Random mix
    for (int i = 0; i < 24; i++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    // Reset while waiting in RESP
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30;
    @(negedge clock);
    req_valid = 1'b0;
    check_eq("rr_mem_req", {31'h0, io_mem_req}, 32'h1);
    mem_gnt = 1'b1;
    @(negedge clock);
    mem_gnt = 1'b0;
    check_eq("rr_in_resp", {31'h0, io_busy & ~io_mem_req}, 32'h1);
    reset = 1'b1;
    #1;
    check_eq("rr_mem_req_low", {31'h0, io_mem_req}, 32'h0);
    check_eq("rr_busy_low", {31'h0, io_busy}, 32'h0);
    check_eq("rr_done_low", {31'h0, io_done}, 32'h0);
    check_eq("rr_rdata_zero", io_rdata, 32'h0);
    model_rdata = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
    @(negedge clock);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("rr_no_done", {31'h0, io_done}, 32'h0);
      check_eq("rr_idle", {31'h0, io_busy}, 32'h0);
      @(negedge clock);
    end

    // Normal operation after reset
    access(1'b0, 3'b001, 32'h36, 32'h0, 32'h7FFE0000, 1, 0, 0);
    check_eq("post_reset_lh", obs_rdata, 32'h00007FFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
